adder_rr_arbiter: RTL and testbench
===================================

ADDER_RR_ARBITER -- requirements
Module: adder_rr_arbiter

Interface
REQ-001 Parameter W, default 32, operand/result width in bits.
REQ-002 Parameter NREQ, default 4, number of requesters; power of two, at least 2.
REQ-003 Parameter BLK, default 4, carry-bypass block size passed to the adder; W SHALL be a multiple of BLK.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 req  input  NREQ  per-requester request; held high with stable operands until granted.
REQ-007 a_flat  input  NREQ*W  operand A of requester i at bits [W*i+W-1 : W*i], signed.
REQ-008 b_flat  input  NREQ*W  operand B, packed the same way, signed.
REQ-009 cin_vec  input  NREQ  carry-in per requester.
REQ-010 grant  output  NREQ  one-hot, combinational; grant[i]=1 means requester i's operands are captured at this clock edge.
REQ-011 res_valid  output  1  result register holds an unconsumed result.
REQ-012 res_ready  input  1  consumer accepts the result when res_valid and res_ready are both high at a clock edge.
REQ-013 res_id  output  log2(NREQ)  index of the requester that owns the current result.
REQ-014 sum  output  W  signed sum a+b+cin, modulo 2^W.
REQ-015 cout  output  1  carry out of bit W-1.
REQ-016 overflow  output  1  two's-complement signed overflow of the addition.
REQ-017 busy  output  1  high when the stage-1 register or the result register is valid.

Function
REQ-018 Pipeline SHALL be 2 stages: stage 1 (operand register, s1_valid) feeds one carry_bypass_adder instance (W, BLK); stage 2 is the result register.
REQ-019 Stage 2 SHALL be able to load when res_valid=0 or res_ready=1 (load_s2).
REQ-020 Stage 1 SHALL be able to load when s1_valid=0 or load_s2=1 (accept).
REQ-021 grant SHALL be all-zero when accept=0 or req=0; otherwise it SHALL be exactly one bit, set for the winning requester.
REQ-022 Arbitration SHALL be round-robin: the search starts at index (last+1) mod NREQ and wraps, where last is the most recently granted index.
REQ-023 The last-grant pointer SHALL update only on an edge where a grant is issued.
REQ-024 On a grant, stage 1 SHALL capture that requester's a, b and cin together with its id, and set s1_valid=1.
REQ-025 When no grant is issued and load_s2=1, s1_valid SHALL clear.
REQ-026 On load_s2 with s1_valid=1, the result register SHALL capture sum, cout, overflow and id, and set res_valid=1.
REQ-027 On load_s2 with s1_valid=0, res_valid SHALL clear.
REQ-028 While res_valid=1 and res_ready=0, sum, cout, overflow and res_id SHALL stay stable.
REQ-029 Latency: a grant at edge t SHALL produce res_valid high after edge t+1 when there is no backpressure.
REQ-030 Throughput SHALL be one grant per cycle while res_ready=1.
REQ-031 overflow SHALL equal (a[W-1] & b[W-1] & ~sum[W-1]) | (~a[W-1] & ~b[W-1] & sum[W-1]).
REQ-032 A single requester holding req continuously SHALL be granted every cycle that accept=1.
REQ-033 With all requesters active, each SHALL be granted once in any NREQ consecutive grants.
REQ-034 A req that drops before it is granted SHALL be ignored, with no state change.

Reset
REQ-035 While rst=1, s1_valid, res_valid, sum, cout, overflow and res_id SHALL be 0, and last SHALL be NREQ-1 so that index 0 has first priority.
REQ-036 grant SHALL be 0 while rst=1.
REQ-037 Asserting rst mid-operation SHALL discard all in-flight operations immediately; no partial result SHALL appear after release.

Verification
REQ-038 Reset, then req=4'b0001 for one cycle with A0=5, B0=7, cin=0: grant=0001 in that cycle; two edges later res_valid=1, res_id=0, sum=12, cout=0, overflow=0.
REQ-039 req=4'b1111 held, res_ready=1: grants follow 0001,0010,0100,1000,0001; res_id follows 0,1,2,3,0 with one result per cycle.
REQ-040 Requester 2 issues A=0x7FFFFFFF, B=1, cin=0: sum=0x80000000, overflow=1, cout=0. Requester 3 issues A=0xFFFFFFFF, B=1, cin=1: sum=1, cout=1, overflow=0.
REQ-041 Backpressure: req=1111 with res_ready=0: exactly two grants occur, then grant=0 and the result stays stable; raising res_ready resumes grants in round-robin order with no result lost or duplicated.
REQ-042 Assert rst while s1_valid=1 and res_valid=1: outputs go to 0 without waiting for a clock edge. After release with req=1111, the first grant=0001.

Source files
------------

// File: rtl/adder_rr_arbiter_if.sv
// rtl/adder_rr_arbiter_if.sv - request/result bundle for the round-robin adder
//
// Groups every handshake and data signal of adder_rr_arbiter.
//   req, a_flat, b_flat, cin_vec : per-requester operands (requester i at slice i)
//   grant                        : one-hot, combinational, operands captured this edge
//   res_valid/res_ready          : result handshake
//   res_id, sum, cout, overflow  : result payload
//   busy                         : pipeline holds anything
// master drives requests and res_ready; slave is the arbiter/adder.

interface adder_rr_arbiter_if #(
    parameter int W    = 32,
    parameter int NREQ = 4
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] a_flat;
    logic [NREQ*W-1:0] b_flat;
    logic [NREQ-1:0]   cin_vec;
    logic [NREQ-1:0]   grant;
    logic              res_valid;
    logic              res_ready;
    logic [IDW-1:0]    res_id;
    logic [W-1:0]      sum;
    logic              cout;
    logic              overflow;
    logic              busy;

    modport master (
        output req, a_flat, b_flat, cin_vec, res_ready,
        input  grant, res_valid, res_id, sum, cout, overflow, busy
    );

    modport slave (
        input  req, a_flat, b_flat, cin_vec, res_ready,
        output grant, res_valid, res_id, sum, cout, overflow, busy
    );
endinterface

// File: rtl/adder_rr_arbiter.sv
// rtl/adder_rr_arbiter.sv - round-robin arbitrated two-stage signed adder
//
// carry_bypass_adder : W-bit adder built from BLK-bit ripple blocks; a block whose
//                      bits all propagate passes its carry-in straight through.
//   a, b, cin -> sum, cout
//
// adder_rr_arbiter   : NREQ requesters compete for one adder. The winner's
//                      operands go into stage 1, the adder output is captured in
//                      the stage-2 result register.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : adder_rr_arbiter_if.slave (requests, grant, result handshake, busy)

module carry_bypass_adder #(
    parameter int W   = 32,
    parameter int BLK = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);
    localparam int NB = W / BLK;

    logic [W-1:0] s;
    logic         carry;
    logic         blk_in;
    logic         rc;
    logic         prop;
    logic         p;

    always_comb begin
        s      = '0;
        carry  = cin;
        blk_in = 1'b0;
        rc     = 1'b0;
        prop   = 1'b0;
        p      = 1'b0;
        for (int k = 0; k < NB; k++) begin
            blk_in = carry;
            rc     = carry;
            prop   = 1'b1;
            for (int j = 0; j < BLK; j++) begin
                p             = a[k*BLK+j] ^ b[k*BLK+j];
                s[k*BLK+j]    = p ^ rc;
                rc            = (a[k*BLK+j] & b[k*BLK+j]) | (p & rc);
                prop          = prop & p;
            end
            // Full-propagate block: carry-out equals carry-in, skip the ripple.
            carry = prop ? blk_in : rc;
        end
        sum  = s;
        cout = carry;
    end
endmodule

module adder_rr_arbiter #(
    parameter int W    = 32,
    parameter int NREQ = 4,
    parameter int BLK  = 4
) (
    input logic             clk,
    input logic             rst,
    adder_rr_arbiter_if.slave bus
);
    localparam int IDW = $clog2(NREQ);

    // Stage 1: operand register
    logic           s1_valid;
    logic [W-1:0]   s1_a;
    logic [W-1:0]   s1_b;
    logic           s1_cin;
    logic [IDW-1:0] s1_id;

    // Stage 2: result register
    logic           res_valid;
    logic [W-1:0]   res_sum;
    logic           res_cout;
    logic           res_ovf;
    logic [IDW-1:0] res_id;

    logic [IDW-1:0] last;
    logic [IDW-1:0] win_id;
    logic [IDW-1:0] cand;
    logic           found;
    logic           gnt_valid;
    logic           load_s2;
    logic           accept;

    logic [W-1:0]   add_sum;
    logic           add_cout;
    logic           add_ovf;

    assign load_s2 = ~res_valid | bus.res_ready;
    assign accept  = ~s1_valid | load_s2;

    // Search starts one past the last winner and wraps; the final candidate
    // (offset NREQ) is the last winner itself, so a lone requester keeps winning.
    always_comb begin
        found  = 1'b0;
        win_id = last;
        cand   = last;
        for (int off = 1; off <= NREQ; off++) begin
            cand = last + IDW'(off);
            if (!found && bus.req[cand]) begin
                found  = 1'b1;
                win_id = cand;
            end
        end
    end

    assign gnt_valid = found & accept & ~rst;
    assign bus.grant = gnt_valid ? ({{(NREQ-1){1'b0}}, 1'b1} << win_id) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last     <= IDW'(NREQ - 1);
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_cin   <= 1'b0;
            s1_id    <= '0;
        end else if (gnt_valid) begin
            last     <= win_id;
            s1_valid <= 1'b1;
            s1_a     <= bus.a_flat[int'(win_id)*W +: W];
            s1_b     <= bus.b_flat[int'(win_id)*W +: W];
            s1_cin   <= bus.cin_vec[win_id];
            s1_id    <= win_id;
        end else if (load_s2) begin
            s1_valid <= 1'b0;
        end
    end

    carry_bypass_adder #(
        .W   (W),
        .BLK (BLK)
    ) u_add (
        .a    (s1_a),
        .b    (s1_b),
        .cin  (s1_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    assign add_ovf = (s1_a[W-1] & s1_b[W-1] & ~add_sum[W-1]) |
                     (~s1_a[W-1] & ~s1_b[W-1] & add_sum[W-1]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_sum   <= '0;
            res_cout  <= 1'b0;
            res_ovf   <= 1'b0;
            res_id    <= '0;
        end else if (load_s2) begin
            if (s1_valid) begin
                res_valid <= 1'b1;
                res_sum   <= add_sum;
                res_cout  <= add_cout;
                res_ovf   <= add_ovf;
                res_id    <= s1_id;
            end else begin
                res_valid <= 1'b0;
            end
        end
    end

    assign bus.res_valid = res_valid;
    assign bus.sum       = res_sum;
    assign bus.cout      = res_cout;
    assign bus.overflow  = res_ovf;
    assign bus.res_id    = res_id;
    assign bus.busy      = s1_valid | res_valid;
endmodule

// File: tb/tb_adder_rr_arbiter.sv
// tb/tb_adder_rr_arbiter.sv - bench for adder_rr_arbiter

module tb_adder_rr_arbiter;
    localparam int W    = 32;
    localparam int NREQ = 4;

    logic clk;
    logic rst;

    adder_rr_arbiter_if #(.W(W), .NREQ(NREQ)) ifc ();

    adder_rr_arbiter #(.W(W), .NREQ(NREQ), .BLK(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  id;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        int          age;
    } op_t;

    op_t        pipe[$];
    int         last_m;
    logic [3:0] last_grant;
    logic [3:0] dut_grant;
    int         n_tests;
    int         n_fail;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic op_t ref_add(input int id, input logic [31:0] a,
                                    input logic [31:0] b, input logic cin);
        op_t         o;
        logic [32:0] full;
        longint      ss;
        full  = {1'b0, a} + {1'b0, b} + {32'd0, cin};
        ss    = longint'($signed(a)) + longint'($signed(b)) + longint'(cin);
        o.id  = 2'(id);
        o.sum = full[31:0];
        o.cout = full[32];
        o.ovf = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
        o.age = 0;
        return o;
    endfunction

    // One clock: compare at the falling edge, advance the model after the rising edge.
    task automatic step();
        int         n;
        logic [3:0] eg;
        logic       ev;
        logic       acc;
        int         gi;
        op_t        o;
        @(negedge clk);
        n   = pipe.size();
        acc = (n < 2) || ifc.res_ready;
        eg  = 4'b0000;
        gi  = -1;
        if (acc && !rst) begin
            for (int off = 1; off <= NREQ; off++) begin
                int i;
                i = (last_m + off) % NREQ;
                if (gi < 0 && ifc.req[i]) gi = i;
            end
        end
        if (gi >= 0) eg[gi] = 1'b1;
        ev = (n > 0) && (pipe[0].age >= 1);
        dut_grant = ifc.grant;
        chk("grant", ifc.grant, eg);
        chk("res_valid", ifc.res_valid, ev);
        chk("busy", ifc.busy, n > 0);
        if (ev) begin
            chk("res_id", ifc.res_id, pipe[0].id);
            chk("sum", ifc.sum, pipe[0].sum);
            chk("cout", ifc.cout, pipe[0].cout);
            chk("overflow", ifc.overflow, pipe[0].ovf);
        end
        if (gi >= 0)
            o = ref_add(gi, ifc.a_flat[gi*W +: W], ifc.b_flat[gi*W +: W], ifc.cin_vec[gi]);
        @(posedge clk);
        #1;
        if (ev && ifc.res_ready) void'(pipe.pop_front());
        foreach (pipe[k]) pipe[k].age++;
        if (gi >= 0) begin
            pipe.push_back(o);
            last_m = gi;
        end
        last_grant = eg;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        ifc.req       = '0;
        ifc.res_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        pipe.delete();
        last_m     = NREQ - 1;
        last_grant = '0;
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h7FFF_FFFF;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h0000_0000;
            default: return $urandom;
        endcase
    endfunction

    task automatic drive_random();
        for (int i = 0; i < NREQ; i++) begin
            if (ifc.req[i] && !last_grant[i]) begin
                if ($urandom_range(0, 9) == 0) ifc.req[i] = 1'b0;
            end else begin
                ifc.req[i]            = ($urandom_range(0, 2) != 0);
                ifc.a_flat[i*W +: W]  = pick_operand();
                ifc.b_flat[i*W +: W]  = pick_operand();
                ifc.cin_vec[i]        = 1'($urandom_range(0, 1));
            end
        end
        ifc.res_ready = ($urandom_range(0, 3) != 0);
    endtask

    logic [3:0]  exp_seq [5];
    logic [31:0] held_sum;
    int          gcount;

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        rst           = 1'b0;
        ifc.req       = '0;
        ifc.a_flat    = '0;
        ifc.b_flat    = '0;
        ifc.cin_vec   = '0;
        ifc.res_ready = 1'b1;
        last_m        = NREQ - 1;
        last_grant    = '0;
        #1;
        rst     = 1'b1;
        ifc.req = 4'b1111;
        #1;
        chk("rst_grant", ifc.grant, 4'b0000);
        chk("rst_res_valid", ifc.res_valid, 1'b0);
        chk("rst_sum", ifc.sum, 32'd0);
        chk("rst_busy", ifc.busy, 1'b0);
        do_reset();

        // Single request 5 + 7
        ifc.req              = 4'b0001;
        ifc.a_flat[0 +: W]   = 32'd5;
        ifc.b_flat[0 +: W]   = 32'd7;
        ifc.cin_vec          = '0;
        step();
        chk("d1_grant", dut_grant, 4'b0001);
        ifc.req = 4'b0000;
        step();
        chk("d1_valid", ifc.res_valid, 1'b1);
        chk("d1_id", ifc.res_id, 2'd0);
        chk("d1_sum", ifc.sum, 32'd12);
        chk("d1_cout", ifc.cout, 1'b0);
        chk("d1_ovf", ifc.overflow, 1'b0);
        step();

        // All requesters held: strict rotation starting at 0
        do_reset();
        exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0010; exp_seq[2] = 4'b0100;
        exp_seq[3] = 4'b1000; exp_seq[4] = 4'b0001;
        for (int i = 0; i < NREQ; i++) begin
            ifc.a_flat[i*W +: W] = 32'(100 * i);
            ifc.b_flat[i*W +: W] = 32'(i + 1);
        end
        ifc.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("rr_seq", dut_grant, exp_seq[k]);
        end
        ifc.req = 4'b0000;
        repeat (3) step();

        // Overflow and carry corners
        do_reset();
        ifc.req              = 4'b0100;
        ifc.a_flat[2*W +: W] = 32'h7FFF_FFFF;
        ifc.b_flat[2*W +: W] = 32'h0000_0001;
        ifc.cin_vec          = 4'b0000;
        step();
        ifc.req              = 4'b1000;
        ifc.a_flat[3*W +: W] = 32'hFFFF_FFFF;
        ifc.b_flat[3*W +: W] = 32'h0000_0001;
        ifc.cin_vec          = 4'b1000;
        step();
        chk("ov_sum", ifc.sum, 32'h8000_0000);
        chk("ov_ovf", ifc.overflow, 1'b1);
        chk("ov_cout", ifc.cout, 1'b0);
        ifc.req = 4'b0000;
        step();
        chk("cy_sum", ifc.sum, 32'd1);
        chk("cy_cout", ifc.cout, 1'b1);
        chk("cy_ovf", ifc.overflow, 1'b0);
        step();

        // Backpressure: exactly two grants, result held, then drains in order
        do_reset();
        ifc.req       = 4'b1111;
        ifc.res_ready = 1'b0;
        gcount        = 0;
        held_sum      = '0;
        for (int k = 0; k < 6; k++) begin
            step();
            gcount += $countones(dut_grant);
            if (k == 2) held_sum = ifc.sum;
        end
        chk("bp_grants", gcount, 2);
        chk("bp_stable", ifc.sum, held_sum);
        ifc.res_ready = 1'b1;
        repeat (8) step();
        ifc.req = 4'b0000;
        repeat (3) step();

        // Mid-flight reset clears outputs without a clock edge
        do_reset();
        ifc.req       = 4'b1111;
        ifc.res_ready = 1'b0;
        repeat (2) step();
        chk("mr_full", ifc.busy, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("mr_valid", ifc.res_valid, 1'b0);
        chk("mr_busy", ifc.busy, 1'b0);
        chk("mr_grant", ifc.grant, 4'b0000);
        chk("mr_sum", ifc.sum, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        pipe.delete();
        last_m        = NREQ - 1;
        last_grant    = '0;
        ifc.req       = 4'b1111;
        ifc.res_ready = 1'b1;
        step();
        chk("mr_first", dut_grant, 4'b0001);
        ifc.req = 4'b0000;
        repeat (3) step();

        // Randomized traffic against the reference model
        do_reset();
        for (int k = 0; k < 400; k++) begin
            drive_random();
            step();
        end
        ifc.req       = 4'b0000;
        ifc.res_ready = 1'b1;
        repeat (4) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
